alu_multicycle: RTL and testbench



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_multicycle_mul_div_iter.sv | 104 ++++++++++
 rtl/alu_multicycle.sv | 164 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode-class helpers for the
// multicycle RV32I/RV32M execution unit.
package alu_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_ADD    = 5'b00000;
  localparam logic [OPW-1:0] OP_SLT    = 5'b00001;
  localparam logic [OPW-1:0] OP_SLTU   = 5'b00010;
  localparam logic [OPW-1:0] OP_XOR    = 5'b00011;
  localparam logic [OPW-1:0] OP_OR     = 5'b00100;
  localparam logic [OPW-1:0] OP_AND    = 5'b00111;
  localparam logic [OPW-1:0] OP_SLL    = 5'b01000;
  localparam logic [OPW-1:0] OP_SRL    = 5'b01001;
  localparam logic [OPW-1:0] OP_SRA    = 5'b01010;
  localparam logic [OPW-1:0] OP_SUB    = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL    = 5'b10000;
  localparam logic [OPW-1:0] OP_MULH   = 5'b10001;
  localparam logic [OPW-1:0] OP_MULHSU = 5'b10010;
  localparam logic [OPW-1:0] OP_MULHU  = 5'b10011;
  localparam logic [OPW-1:0] OP_DIV    = 5'b10100;
  localparam logic [OPW-1:0] OP_DIVU   = 5'b10101;
  localparam logic [OPW-1:0] OP_REM    = 5'b10110;
  localparam logic [OPW-1:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_mul(input logic [OPW-1:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [OPW-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_multicycle_mul_div_iter.sv
// Iterative multiply (radix-2 shift-add) and restoring divide on operand
// magnitudes; sign fix-up is applied combinationally on the final step.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mq_q, mq_d;
  logic [XLEN-1:0] opb_q;
  logic            div_q, hi_q, rem_q, neg_q;

  logic            sign_a_c, sign_b_c, rem_op_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;

  // Operand sign extraction and magnitudes at start
  always_comb begin
    rem_op_c = (op_i == OP_REM) || (op_i == OP_REMU);
    sign_a_c = a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                              (op_i == OP_DIV)  || (op_i == OP_REM));
    sign_b_c = b_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_DIV) ||
                              (op_i == OP_REM));
    mag_a_c  = sign_a_c ? -a_i : a_i;
    mag_b_c  = sign_b_c ? -b_i : b_i;
  end

  logic [XLEN:0]     sum_c, rsh_c, diff_c;
  logic              qbit_c;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   div_raw_c;

  // One iteration step; {acc,mq} holds the product or remainder/quotient
  always_comb begin
    sum_c  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    rsh_c  = {acc_q, mq_q[XLEN-1]};
    diff_c = rsh_c - {1'b0, opb_q};
    qbit_c = ~diff_c[XLEN];
    if (div_q) begin
      acc_d = qbit_c ? diff_c[XLEN-1:0] : rsh_c[XLEN-1:0];
      mq_d  = {mq_q[XLEN-2:0], qbit_c};
    end else begin
      acc_d = sum_c[XLEN:1];
      mq_d  = {sum_c[0], mq_q[XLEN-1:1]};
    end
    prod_c    = neg_q ? -{acc_d, mq_d} : {acc_d, mq_d};
    div_raw_c = rem_q ? acc_d : mq_d;
    div_raw_c = neg_q ? -div_raw_c : div_raw_c;
    result_c  = div_q ? div_raw_c
                      : (hi_q ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0]);
  end

  assign done_c = busy_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(XLEN - 1);
      acc_q  <= '0;
      mq_q   <= mag_a_c;
      opb_q  <= mag_b_c;
      div_q  <= is_div(op_i);
      hi_q   <= (op_i != OP_MUL);
      rem_q  <= rem_op_c;
      neg_q  <= rem_op_c ? sign_a_c : (sign_a_c ^ sign_b_c);
    end else if (busy_q) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked execution unit: single-cycle base ops, iterative M-extension
// ops, registered result/flags held until the consumer takes them.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            less_flag
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q;
  logic            zero_q, less_q;

  logic            start_c, load_acc_c, load_iter_c;
  logic            iter_done_c;
  logic [XLEN-1:0] iter_res_c;

  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] base_res_c, acc_res_c, special_res_c;
  logic            base_less_c, acc_less_c;
  logic            m_op_c, div_zero_c, div_ovf_c, div_special_c, rem_op_c;

  assign shamt_c = b[SHW-1:0];

  // Single-cycle base operations; undefined codes yield 0
  always_comb begin
    base_res_c  = '0;
    base_less_c = 1'b0;
    case (op)
      OP_ADD:  base_res_c = a + b;
      OP_SUB:  base_res_c = a - b;
      OP_SLT: begin
        base_less_c = $signed(a) < $signed(b);
        base_res_c  = XLEN'(base_less_c);
      end
      OP_SLTU: begin
        base_less_c = a < b;
        base_res_c  = XLEN'(base_less_c);
      end
      OP_XOR:  base_res_c = a ^ b;
      OP_OR:   base_res_c = a | b;
      OP_AND:  base_res_c = a & b;
      OP_SLL:  base_res_c = a << shamt_c;
      OP_SRL:  base_res_c = a >> shamt_c;
      OP_SRA:  base_res_c = XLEN'($signed(a) >>> shamt_c);
      default: ;
    endcase
  end

  // Divide corner cases resolved without iterating
  always_comb begin
    m_op_c        = ENABLE_M && (is_mul(op) || is_div(op));
    rem_op_c      = (op == OP_REM) || (op == OP_REMU);
    div_zero_c    = (b == '0);
    div_ovf_c     = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    div_special_c = ENABLE_M && is_div(op) && (div_zero_c || div_ovf_c);
    if (div_zero_c) begin
      special_res_c = rem_op_c ? a : '1;
    end else begin
      special_res_c = rem_op_c ? '0 : a;
    end
    acc_res_c  = div_special_c ? special_res_c : base_res_c;
    acc_less_c = div_special_c ? 1'b0 : base_less_c;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    load_acc_c  = 1'b0;
    load_iter_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (m_op_c && !div_special_c) begin
            start_c = 1'b1;
            state_d = is_mul(op) ? MUL : DIV;
          end else begin
            load_acc_c = 1'b1;
            state_d    = DONE;
          end
        end
      end
      MUL, DIV: begin
        if (iter_done_c) begin
          load_iter_c = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      start_c     = 1'b0;
      load_acc_c  = 1'b0;
      load_iter_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
    end else if (load_acc_c) begin
      result_q <= acc_res_c;
      zero_q   <= (acc_res_c == '0);
      less_q   <= acc_less_c;
    end else if (load_iter_c) begin
      result_q <= iter_res_c;
      zero_q   <= (iter_res_c == '0);
      less_q   <= 1'b0;
    end
  end

  if (ENABLE_M) begin : g_m
    mul_div_iter #(.XLEN(XLEN)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flush),
      .start_i  (start_c),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .done_c   (iter_done_c),
      .result_c (iter_res_c)
    );
  end else begin : g_no_m
    assign iter_done_c = 1'b0;
    assign iter_res_c  = '0;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign less_flag = less_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: expected results queued at issue,
// compared by an independent monitor at each result handshake.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        out_valid, out_ready, zero_flag, less_flag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res_q[$];
  logic        exp_less_q[$];
  string       exp_nm_q[$];

  alu_multicycle #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_flag (zero_flag),
    .less_flag (less_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic void push(input string nm, input logic [31:0] r, input logic l);
    exp_nm_q.push_back(nm);
    exp_res_q.push_back(r);
    exp_less_q.push_back(l);
  endfunction

  // Monitor: compare each taken result with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_res_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        string       nm;
        logic [31:0] er;
        logic        el, ez;
        nm = exp_nm_q.pop_front();
        er = exp_res_q.pop_front();
        el = exp_less_q.pop_front();
        ez = (er == 32'h0);
        if (result !== er || zero_flag !== ez || less_flag !== el) begin
          n_fail++;
          $display("FAIL %s: got res=%h z=%b l=%b expected res=%h z=%b l=%b",
                   nm, result, zero_flag, less_flag, er, ez, el);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input string nm);
    int guard;
    int lat;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    if (exp_lat > 0) begin
      lat = 1;
      while (!out_valid && lat < 200) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_res_q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 32'(exp_res_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_result"},    result,           32'h0);
    chk({nm, "_zero"},      32'(zero_flag),   32'd0);
    chk({nm, "_less"},      32'(less_flag),   32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({nm, "_in_ready"},  32'(in_ready),    32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Reset during a multiply at count 10
    issue(OP_MUL, 32'd3, 32'd5, 0, "mul_aborted");
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_mid_mul");
    @(negedge clk);
    rst_n = 1'b1;
    push("add_after_reset", 32'd12, 1'b0);
    issue(OP_ADD, 32'd5, 32'd7, 1, "add_after_reset");

    // Base operations
    push("slt", 32'd1, 1'b1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1, "slt");
    push("sltu", 32'd0, 1'b0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1, "sltu");
    push("sub_zero", 32'd0, 1'b0);
    issue(OP_SUB, 32'd3, 32'd3, 1, "sub_zero");
    push("sra", 32'hF800_0000, 1'b0);
    issue(OP_SRA, 32'h8000_0000, 32'd4, 1, "sra");
    push("srl", 32'h0800_0000, 1'b0);
    issue(OP_SRL, 32'h8000_0000, 32'd4, 1, "srl");
    push("sll_masked", 32'd2, 1'b0);
    issue(OP_SLL, 32'd1, 32'd33, 1, "sll_masked");
    push("and", 32'h0000_F000, 1'b0);
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1, "and");
    push("or", 32'h0000_00FF, 1'b0);
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 1, "or");
    push("undef_op", 32'd0, 1'b0);
    issue(5'b11111, 32'h1234_5678, 32'h1111_1111, 1, "undef_op");

    // Multiplies
    push("mulh", 32'h4000_0000, 1'b0);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 33, "mulh");
    push("mulhu", 32'hFFFF_FFFE, 1'b0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhu");
    push("mul_neg", 32'hFFFF_FFEB, 1'b0);
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 33, "mul_neg");
    push("mulhsu", 32'hFFFF_FFFF, 1'b0);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 33, "mulhsu");

    // Divides and corner cases
    push("div_neg", 32'hFFFF_FFFD, 1'b0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, "div_neg");
    push("rem_neg", 32'hFFFF_FFFF, 1'b0);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 33, "rem_neg");
    push("divu", 32'd14, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7, 33, "divu");
    push("remu", 32'd2, 1'b0);
    issue(OP_REMU, 32'd100, 32'd7, 33, "remu");
    push("divu_by_zero", 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIVU, 32'd5, 32'd0, 1, "divu_by_zero");
    push("rem_by_zero", 32'h0000_1234, 1'b0);
    issue(OP_REM, 32'h0000_1234, 32'd0, 1, "rem_by_zero");
    push("div_ovf", 32'h8000_0000, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
    push("rem_ovf", 32'd0, 1'b0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, "rem_ovf");

    // Backpressure on the result port
    drain();
    out_ready = 1'b0;
    push("bp_add", 32'd3, 1'b0);
    push("bp_xor", 32'h0000_00FF, 1'b0);
    issue(OP_ADD, 32'd1, 32'd2, 1, "bp_add");
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        op = OP_XOR; a = 32'h0000_00F0; b = 32'h0000_000F; in_valid = 1'b1;
      end
      chk("bp_result_stable", result, 32'd3);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_no_accept_at_handshake", 32'({in_ready, out_valid}), 32'b10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(out_valid), 32'd1);
    drain();

    // Flush during a divide at count 20
    issue(OP_DIV, 32'd100, 32'd3, 0, "div_flushed");
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_out_valid", 32'(seen), 32'd0);
    push("xor_after_flush", 32'h0000_000F, 1'b0);
    issue(OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 1, "xor_after_flush");

    drain();
    held = 32'(exp_res_q.size());
    chk("scoreboard_empty", held, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
